// File: rtl/adc_capture_ctrl_pkg.sv
// Shared types and widths for the ADC capture front-end.
// SAMPLE_W and IDX_W are also used by the correlator and echo_tof blocks.
package adc_capture_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_BLANK   = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_DONE    = 2'd3
    } cap_state_e;

    localparam int SAMPLE_W = 12;
    localparam int IDX_W    = 20;
    localparam int BLANK_W  = 16;
    localparam int DECIM_W  = 8;

endpackage

// File: rtl/capture_decim_strobe.sv
// Decimation strobe: passes 1 of every DECIM adc_valid strobes while enabled.
// The first strobe after clear is always the one that gets accepted.
module capture_decim_strobe
    import adc_capture_ctrl_pkg::*;
#(
    parameter int DECIM = 2
) (
    input  logic clk_50M,
    input  logic rst_n,
    input  logic adc_valid,
    input  logic clear,
    input  logic enable,
    output logic accept
);

    localparam logic [DECIM_W-1:0] LAST = DECIM_W'(DECIM - 1);

    logic [DECIM_W-1:0] phase_cnt;

    always_ff @(posedge clk_50M or negedge rst_n) begin
        if (!rst_n) begin
            phase_cnt <= '0;
        end else if (clear) begin
            phase_cnt <= '0;
        end else if (enable && adc_valid) begin
            phase_cnt <= (phase_cnt == LAST) ? '0 : phase_cnt + 1'b1;
        end
    end

    assign accept = enable && adc_valid && (phase_cnt == '0);

endmodule

// File: rtl/adc_capture_ctrl.sv
// ADC capture controller: arm on transmit, blank ring-down, decimate and
// write DEPTH samples into the correlator FIFO.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   IDLE    | waiting for sys_start_pulse; sample_cnt/overflow hold
//   BLANK   | discarding blank_len ADC strobes of transmit ring-down
//   CAPTURE | decimating and writing samples until DEPTH accounted for
//   DONE    | one-cycle capture_done, then back to IDLE
module adc_capture_ctrl
    import adc_capture_ctrl_pkg::*;
#(
    parameter int DATA_W = SAMPLE_W,
    parameter int DEPTH  = 5000,
    parameter int DECIM  = 2
) (
    input  logic               clk_50M,
    input  logic               rst_n,
    input  logic               sys_start_pulse,
    input  logic               abort,
    input  logic [DATA_W-1:0]  adc_data,
    input  logic               adc_valid,
    input  logic [BLANK_W-1:0] blank_len,
    input  logic               fifo_full,
    output logic [DATA_W-1:0]  fifo_data,
    output logic               fifo_wrreq,
    output logic               busy,
    output logic               capture_done,
    output logic               overflow,
    output logic [IDX_W-1:0]   sample_cnt
);

    localparam logic [IDX_W-1:0] DEPTH_C = IDX_W'(DEPTH);

    cap_state_e         state, next_state;
    logic [BLANK_W-1:0] blank_target;
    logic [BLANK_W-1:0] blank_cnt;
    logic [BLANK_W-1:0] blank_cnt_inc;
    logic [IDX_W-1:0]   sample_cnt_inc;
    logic               arm;
    logic               accept;

    assign arm            = (state == ST_IDLE) && sys_start_pulse && !abort;
    assign blank_cnt_inc  = blank_cnt + 1'b1;
    assign sample_cnt_inc = sample_cnt + 1'b1;

    capture_decim_strobe #(.DECIM(DECIM)) u_decim (
        .clk_50M   (clk_50M),
        .rst_n     (rst_n),
        .adc_valid (adc_valid),
        .clear     (arm),
        .enable    (state == ST_CAPTURE),
        .accept    (accept)
    );

    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE: begin
                if (arm) next_state = (blank_len != '0) ? ST_BLANK : ST_CAPTURE;
            end
            ST_BLANK: begin
                if (abort)                                          next_state = ST_IDLE;
                else if (adc_valid && blank_cnt_inc == blank_target) next_state = ST_CAPTURE;
            end
            ST_CAPTURE: begin
                if (abort)                                    next_state = ST_IDLE;
                else if (accept && sample_cnt_inc == DEPTH_C) next_state = ST_DONE;
            end
            ST_DONE:  next_state = ST_IDLE;
            default:  next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_50M or negedge rst_n) begin
        if (!rst_n) begin
            state        <= ST_IDLE;
            busy         <= 1'b0;
            capture_done <= 1'b0;
        end else begin
            state        <= next_state;
            busy         <= (next_state == ST_BLANK) || (next_state == ST_CAPTURE);
            capture_done <= (next_state == ST_DONE);
        end
    end

    // Dropped samples still advance sample_cnt so indices stay time-aligned.
    always_ff @(posedge clk_50M or negedge rst_n) begin
        if (!rst_n) begin
            blank_target <= '0;
            blank_cnt    <= '0;
            sample_cnt   <= '0;
            overflow     <= 1'b0;
            fifo_wrreq   <= 1'b0;
            fifo_data    <= '0;
        end else begin
            fifo_wrreq <= accept && !fifo_full;
            if (accept && !fifo_full) fifo_data <= adc_data;
            if (arm) begin
                blank_target <= blank_len;
                blank_cnt    <= '0;
                sample_cnt   <= '0;
                overflow     <= 1'b0;
            end else begin
                if (state == ST_BLANK && adc_valid) blank_cnt <= blank_cnt_inc;
                if (accept) begin
                    sample_cnt <= sample_cnt_inc;
                    if (fifo_full) overflow <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_adc_capture_ctrl.sv
// Scoreboard bench: two instances (DEPTH=8/DECIM=2 and DEPTH=6/DECIM=1)
// share stimulus; a behavioural shot model predicts writes and status.
module tb_adc_capture_ctrl;

    logic        clk_50M = 1'b0;
    logic        rst_n   = 1'b0;
    logic        sys_start_pulse = 1'b0;
    logic        abort = 1'b0;
    logic [11:0] adc_data = '0;
    logic        adc_valid = 1'b0;
    logic [15:0] blank_len = '0;
    logic        fifo_full = 1'b0;

    logic [11:0] fd [2];
    logic        wr [2];
    logic        bz [2];
    logic        dn [2];
    logic        ov [2];
    logic [19:0] sc [2];

    int n_checks = 0;
    int n_pass   = 0;

    always #10 clk_50M = ~clk_50M;

    adc_capture_ctrl #(.DATA_W(12), .DEPTH(8), .DECIM(2)) u_a (
        .clk_50M(clk_50M), .rst_n(rst_n), .sys_start_pulse(sys_start_pulse),
        .abort(abort), .adc_data(adc_data), .adc_valid(adc_valid),
        .blank_len(blank_len), .fifo_full(fifo_full), .fifo_data(fd[0]),
        .fifo_wrreq(wr[0]), .busy(bz[0]), .capture_done(dn[0]),
        .overflow(ov[0]), .sample_cnt(sc[0])
    );

    adc_capture_ctrl #(.DATA_W(12), .DEPTH(6), .DECIM(1)) u_b (
        .clk_50M(clk_50M), .rst_n(rst_n), .sys_start_pulse(sys_start_pulse),
        .abort(abort), .adc_data(adc_data), .adc_valid(adc_valid),
        .blank_len(blank_len), .fifo_full(fifo_full), .fifo_data(fd[1]),
        .fifo_wrreq(wr[1]), .busy(bz[1]), .capture_done(dn[1]),
        .overflow(ov[1]), .sample_cnt(sc[1])
    );

    task automatic chk(input string name, input int inst, input logic [31:0] act,
                       input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s[%0d] actual=%0d required=%0d t=%0t", name, inst, act, exp, $time);
    endtask

    // Model: phase 0 idle, 1 blanking, 2 capturing, 3 done pulse.
    int          dep_m [2] = '{8, 6};
    int          dec_m [2] = '{2, 1};
    int          ph   [2];
    int          skip [2];
    int          k    [2];
    int          cnt  [2];
    bit          ovf  [2];
    logic [11:0] q0 [$];
    logic [11:0] q1 [$];

    task automatic model_step(input int i);
        bit acc;
        acc = 1'b0;
        case (ph[i])
            0: if (sys_start_pulse && !abort) begin
                cnt[i] = 0; ovf[i] = 1'b0; k[i] = 0; skip[i] = int'(blank_len);
                ph[i] = (skip[i] != 0) ? 1 : 2;
            end
            1: if (abort) ph[i] = 0;
               else if (adc_valid) begin
                   skip[i]--;
                   if (skip[i] == 0) ph[i] = 2;
               end
            2: begin
                if (adc_valid) begin
                    if (k[i] % dec_m[i] == 0) begin
                        acc = 1'b1;
                        cnt[i]++;
                        if (fifo_full) ovf[i] = 1'b1;
                        else if (i == 0) q0.push_back(adc_data);
                        else q1.push_back(adc_data);
                    end
                    k[i]++;
                end
                if (abort) ph[i] = 0;
                else if (acc && cnt[i] == dep_m[i]) ph[i] = 3;
            end
            default: ph[i] = 0;
        endcase
    endtask

    always @(posedge clk_50M or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) begin
                ph[i] = 0; skip[i] = 0; k[i] = 0; cnt[i] = 0; ovf[i] = 1'b0;
            end
            q0.delete();
            q1.delete();
        end else begin
            for (int i = 0; i < 2; i++) model_step(i);
        end
    end

    always @(negedge clk_50M) begin
        for (int i = 0; i < 2; i++) begin
            logic [11:0] e;
            int qs;
            qs = (i == 0) ? q0.size() : q1.size();
            if (wr[i]) begin
                if (qs == 0) chk("unexpected_write", i, 32'(wr[i]), 0);
                else begin
                    e = (i == 0) ? q0.pop_front() : q1.pop_front();
                    chk("write_data", i, 32'(fd[i]), 32'(e));
                end
            end else if (qs != 0) begin
                e = (i == 0) ? q0.pop_front() : q1.pop_front();
                chk("missing_write", i, 32'(wr[i]), 1);
            end
            chk("busy", i, 32'(bz[i]), 32'(ph[i] == 1 || ph[i] == 2));
            chk("capture_done", i, 32'(dn[i]), 32'(ph[i] == 3));
            chk("sample_cnt", i, 32'(sc[i]), 32'(cnt[i]));
            chk("overflow", i, 32'(ov[i]), 32'(ovf[i]));
        end
    end

    task automatic step(input logic st, input logic ab, input logic v,
                        input logic [11:0] d, input logic ff, input logic [15:0] bl);
        sys_start_pulse = st; abort = ab; adc_valid = v;
        adc_data = d; fifo_full = ff; blank_len = bl;
        @(posedge clk_50M);
        #1;
    endtask

    task automatic idle(input int n);
        for (int j = 0; j < n; j++) step(0, 0, 0, 12'd0, 0, 16'd0);
    endtask

    task automatic strobes(input int n, input int ff_lo, input int ff_hi);
        for (int j = 0; j < n; j++)
            step(0, 0, 1, 12'(j), (j >= ff_lo && j <= ff_hi), 16'd0);
    endtask

    initial begin
        repeat (3) @(posedge clk_50M);
        #1;
        for (int i = 0; i < 2; i++) begin
            chk("reset_busy", i, 32'(bz[i]), 0);
            chk("reset_wrreq", i, 32'(wr[i]), 0);
            chk("reset_cnt", i, 32'(sc[i]), 0);
        end
        rst_n = 1'b1;
        idle(2);

        // Shot 1: no blanking, strobe every cycle, data = strobe index
        step(1, 0, 0, 12'd0, 0, 16'd0);
        strobes(20, -1, -1);
        idle(3);
        chk("shot1_cnt", 0, 32'(sc[0]), 8);
        chk("shot1_cnt", 1, 32'(sc[1]), 6);

        // Shot 2: blank 3 strobes
        step(1, 0, 0, 12'd0, 0, 16'd3);
        strobes(24, -1, -1);
        idle(3);

        // Shot 3: fifo full during strobes 2 and 3
        step(1, 0, 0, 12'd0, 0, 16'd0);
        strobes(20, 2, 3);
        idle(3);
        chk("shot3_ovf_held", 1, 32'(ov[1]), 1);
        chk("shot3_cnt", 1, 32'(sc[1]), 6);

        // Shot 4: re-arm ignored while busy, abort on A's 3rd accepted sample
        step(1, 0, 0, 12'd0, 0, 16'd0);
        step(0, 0, 1, 12'd0, 0, 16'd0);
        step(1, 0, 1, 12'd1, 0, 16'd0);
        step(0, 0, 1, 12'd2, 0, 16'd0);
        step(0, 0, 1, 12'd3, 0, 16'd0);
        step(0, 1, 1, 12'd4, 0, 16'd0);
        strobes(6, -1, -1);
        chk("abort_cnt", 0, 32'(sc[0]), 3);
        chk("abort_busy", 0, 32'(bz[0]), 0);

        // Shot 5: reset mid-capture, then a clean capture
        step(1, 0, 0, 12'd0, 1, 16'd0);
        strobes(3, 0, 2);
        rst_n = 1'b0;
        #2;
        for (int i = 0; i < 2; i++) begin
            chk("midreset_busy", i, 32'(bz[i]), 0);
            chk("midreset_cnt", i, 32'(sc[i]), 0);
            chk("midreset_ovf", i, 32'(ov[i]), 0);
        end
        idle(2);
        rst_n = 1'b1;
        idle(1);
        step(1, 0, 0, 12'd0, 0, 16'd0);
        strobes(20, -1, -1);
        idle(2);
        chk("post_reset_ovf", 0, 32'(ov[0]), 0);
        chk("post_reset_cnt", 0, 32'(sc[0]), 8);

        // Shot 6: strobe every third cycle
        step(1, 0, 0, 12'd0, 0, 16'd0);
        for (int j = 0; j < 60; j++) step(0, 0, (j % 3 == 0), 12'(j + 100), 0, 16'd0);
        idle(3);

        // Randomized traffic
        for (int j = 0; j < 4000; j++)
            step($urandom_range(0, 19) == 0, $urandom_range(0, 59) == 0,
                 1'($urandom_range(0, 1)), 12'($urandom), $urandom_range(0, 4) == 0,
                 16'($urandom_range(0, 5)));
        idle(20);
        chk("queue_drained", 0, 32'(q0.size()), 0);
        chk("queue_drained", 1, 32'(q1.size()), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/adc_capture_ctrl.md
Name: adc_capture_ctrl

Overview:
Acquisition front-end that sits directly upstream of the echo correlation stage. It arms on the transmit start pulse and discards a programmable number of ADC samples to blank out transmit ring-down. It then decimates the ADC sample stream and writes exactly DEPTH samples into the shared dual-clock sample FIFO that the correlator drains. It reports completion, busy status and FIFO overflow.

Parameters:
DATA_W, 12, ADC sample width and FIFO data width.
DEPTH, 5000, number of decimated samples captured per shot (1..1048575).
DECIM, 2, decimation factor: keep 1 of every DECIM ADC strobes (1..255; 1 = no decimation).

Ports:
clk_50M  in  1  system clock, 50 MHz.
rst_n  in  1  asynchronous active-low reset.
sys_start_pulse  in  1  one-cycle arm pulse, issued at transmit time.
abort  in  1  one-cycle request to cancel the capture in progress.
adc_data  in  DATA_W  ADC sample, unsigned; valid when adc_valid=1.
adc_valid  in  1  one-cycle strobe per ADC conversion, synchronous to clk_50M.
blank_len  in  16  number of ADC strobes to discard after arm; sampled on the start pulse.
fifo_full  in  1  FIFO write-side full flag.
fifo_data  out  DATA_W  registered sample to the FIFO.
fifo_wrreq  out  1  registered FIFO write strobe.
busy  out  1  high in BLANK and CAPTURE.
capture_done  out  1  one-cycle pulse when DEPTH samples have been accounted for.
overflow  out  1  sticky; a sample was dropped because the FIFO was full.
sample_cnt  out  20  decimated samples accounted for in the current or last shot.

Behaviour:
- Reset values: all outputs 0, state IDLE, all internal counters 0. Reset mid-capture aborts immediately; no done pulse.
- States: IDLE, BLANK, CAPTURE, DONE.
- IDLE, on sys_start_pulse (and abort=0):
  - latch blank_len; clear sample_cnt, overflow, blank counter and decimation counter;
  - go to BLANK if the latched value is nonzero, else go to CAPTURE.
- BLANK: count adc_valid strobes. The strobe that brings the count to blank_len is discarded, and the state then moves to CAPTURE. The first CAPTURE sample is the next adc_valid strobe.
- CAPTURE:
  - the decimation counter is 0 on entry; each adc_valid increments it modulo DECIM;
  - a strobe seen while the counter is 0 is an accepted sample, so the first strobe in CAPTURE is always accepted.
- Accepted sample, fifo_full=0: on the next clock fifo_wrreq=1 and fifo_data=adc_data, for exactly one cycle. Latency is 1 clock from the adc_valid edge.
- Accepted sample, fifo_full=1: the sample is dropped, fifo_wrreq stays 0 and overflow is set to 1.
- Every accepted sample increments sample_cnt, whether written or dropped, so correlator indices stay time-aligned in sample count.
- When an accepted sample makes sample_cnt equal DEPTH, go to DONE on the next clock.
- DONE: capture_done=1 for one cycle, then IDLE.
- sample_cnt and overflow hold their values in IDLE until the next arm.
- busy=1 exactly while the state is BLANK or CAPTURE (registered, state-decoded).
- sys_start_pulse in any state other than IDLE is ignored; no re-arm.
- abort in BLANK or CAPTURE:
  - go to IDLE on the next clock with no done pulse;
  - a write already registered in the same cycle still completes;
  - sample_cnt holds its partial value.
- abort and sys_start_pulse in the same cycle in IDLE: abort wins and the state stays IDLE.
- abort in IDLE or DONE has no effect; the done pulse still fires.
- adc_valid with no capture active (IDLE or DONE) is ignored.
- Writes are at most one per adc_valid, so the FIFO is never written more often than the ADC strobe rate.
- Widths: sample_cnt 20 bits, compared against DEPTH; the blank counter is 16 bits; the decimation counter is 8 bits. No wrap-around is possible within the legal parameter ranges.

Decomposition:
- Shared package holds:
  - the state enum (IDLE, BLANK, CAPTURE, DONE);
  - the sample-width constant of 12, shared with the correlator;
  - the 20-bit sample-index width, shared with echo_tof.
- One sub-module is natural: capture_decim_strobe. Inputs: adc_valid, clear, enable. Output: an accept pulse every DECIM strobes, with the first strobe after clear accepted.

Test Plan:
- DEPTH=8, DECIM=2, blank_len=0, adc_valid every cycle, adc_data=0..15, fifo_full=0:
  - 8 writes with data 0,2,4,...,14, each 1 clock after its strobe;
  - capture_done pulses once; sample_cnt=8; busy falls in the same cycle the done pulse rises.
- blank_len=3, DECIM=1, DEPTH=4, adc_data=strobe index 0..9: writes 3,4,5,6; nothing written during BLANK.
- DEPTH=6, DECIM=1, fifo_full held high during strobes 2 and 3:
  - writes 0,1,4,5; overflow=1 and stays high after done;
  - sample_cnt=6; capture_done fires.
- Second sys_start_pulse while busy=1: ignored. abort on the 3rd accepted sample (DEPTH=8):
  - writes stop after that sample;
  - no capture_done; sample_cnt=3; busy=0.
- rst_n asserted mid-CAPTURE: all outputs are 0 immediately. A new start after release gives a clean DEPTH capture with overflow=0.
- adc_valid every 3 cycles, DECIM=2, DEPTH=5: fifo_wrreq pulses exactly every 6 cycles, 5 pulses total.
